// File: rtl/stream_xbar_pkt.sv
// Packet-locked AXI-Stream crossbar: NUM_IN inputs to NUM_OUT outputs through a 2-entry skid buffer.
// Define STREAM_XBAR_BCAST_EN to make the all-ones sel_out code broadcast to every output.
module stream_xbar_pkt #(
    parameter int  NUM_IN    = 6,
    parameter int  NUM_OUT   = 9,
    parameter int  DATA_W    = 1536,
    parameter int  LAST_W    = 12,
    parameter int  CNT_W     = 16,
    localparam int SEL_IN_W  = $clog2(NUM_IN + 1),
    localparam int SEL_OUT_W = $clog2(NUM_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_IN_W-1:0]       sel_in,
    input  logic [SEL_OUT_W-1:0]      sel_out,
    input  logic                      s_side,
    input  logic [NUM_IN*DATA_W-1:0]  s_tdata,
    input  logic [NUM_IN-1:0]         s_tvalid,
    output logic [NUM_IN-1:0]         s_tready,
    input  logic [NUM_IN*LAST_W-1:0]  s_tlast,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [LAST_W-1:0]         m_tlast,
    output logic                      m_side,
    output logic [NUM_OUT-1:0]        m_tvalid,
    input  logic [NUM_OUT-1:0]        m_tready,
    output logic                      busy,
    output logic                      pkt_done,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      err_drop
);

    localparam logic [SEL_OUT_W-1:0] NUM_OUT_C = SEL_OUT_W'(NUM_OUT);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic                   lock_load;
    logic [SEL_IN_W-1:0]    lock_in_q, eff_in;
    logic [SEL_OUT_W-1:0]   lock_out_q, eff_out;

    logic [DATA_W-1:0]      buf_data_p1 [2];
    logic [LAST_W-1:0]      buf_last_p1 [2];
    logic                   buf_side_p1 [2];
    logic [SEL_OUT_W-1:0]   buf_idx_p1  [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;
    logic                   full, empty;

    logic                   vld_p0;
    logic [DATA_W-1:0]      data_p0;
    logic [LAST_W-1:0]      last_p0;
    logic                   push, pop, drop, ready_sel, idx_ok;
    logic [SEL_OUT_W-1:0]   head_idx;
    logic [LAST_W-1:0]      head_last;

`ifdef STREAM_XBAR_BCAST_EN
    logic                   is_bcast;
    logic [NUM_OUT-1:0]     done_mask;
`endif

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign busy  = (state_q == LOCKED) | ~empty;

    // Stage p0: select the effective lane and mask every other input
    always_comb begin
        eff_in   = (state_q == LOCKED) ? lock_in_q  : sel_in;
        eff_out  = (state_q == LOCKED) ? lock_out_q : sel_out;
        s_tready = '0;
        vld_p0   = 1'b0;
        data_p0  = '0;
        last_p0  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (eff_in == SEL_IN_W'(i + 1)) begin
                s_tready[i] = ~full & ~rst;
                vld_p0      = s_tvalid[i];
                data_p0     = s_tdata[i*DATA_W +: DATA_W];
                last_p0     = s_tlast[i*LAST_W +: LAST_W];
            end
        end
        push = vld_p0 & ~full & ~rst;
    end

    always_comb begin
        state_d   = state_q;
        lock_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (push && (last_p0 == '0)) begin
                    state_d   = LOCKED;
                    lock_load = 1'b1;
                end
            end
            LOCKED: begin
                if (push && (last_p0 != '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_in_q  <= '0;
            lock_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (lock_load) begin
                lock_in_q  <= eff_in;
                lock_out_q <= eff_out;
            end
        end
    end

    // Stage p1: buffer head drives the shared output bus
    assign head_idx  = buf_idx_p1[rd_ptr];
    assign head_last = buf_last_p1[rd_ptr];
    assign m_tdata   = buf_data_p1[rd_ptr];
    assign m_tlast   = head_last;
    assign m_side    = buf_side_p1[rd_ptr];
    assign idx_ok    = (head_idx < NUM_OUT_C);
`ifdef STREAM_XBAR_BCAST_EN
    assign is_bcast  = (head_idx == '1);
`endif

    always_comb begin
        m_tvalid  = '0;
        ready_sel = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (head_idx == SEL_OUT_W'(j)) begin
                m_tvalid[j] = ~empty;
                ready_sel   = m_tready[j];
            end
        end
        if (idx_ok) begin
            pop = ~empty & ready_sel;
        end
`ifdef STREAM_XBAR_BCAST_EN
        else if (is_bcast) begin
            m_tvalid = {NUM_OUT{~empty}} & ~done_mask;
            pop      = ~empty & (&(done_mask | m_tready));
        end
`endif
        else begin
            drop = ~empty;
            pop  = ~empty;
        end
    end

    // Output bus must read zero after reset, so the buffer contents are cleared too
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                buf_data_p1[k] <= '0;
                buf_last_p1[k] <= '0;
                buf_side_p1[k] <= 1'b0;
                buf_idx_p1[k]  <= '0;
            end
        end else if (push) begin
            buf_data_p1[wr_ptr] <= data_p0;
            buf_last_p1[wr_ptr] <= last_p0;
            buf_side_p1[wr_ptr] <= s_side;
            buf_idx_p1[wr_ptr]  <= eff_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            beat_cnt <= '0;
            err_drop <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count    <= count + {1'b0, push} - {1'b0, pop};
            beat_cnt <= beat_cnt + CNT_W'(push);
            if (drop) err_drop <= 1'b1;
            pkt_done <= pop & (|head_last);
        end
    end

`ifdef STREAM_XBAR_BCAST_EN
    // Outputs that already took the broadcast head are remembered until it pops
    always_ff @(posedge clk) begin
        if (rst || pop) begin
            done_mask <= '0;
        end else if (!empty && is_bcast) begin
            done_mask <= done_mask | (m_tready & m_tvalid);
        end
    end
`endif

endmodule

// File: tb/tb_stream_xbar_pkt.sv
// Self-checking bench for stream_xbar_pkt: directed scenarios plus randomized traffic
// scored against a queue-based packet model.
module tb_stream_xbar_pkt;

    localparam int NUM_IN  = 6;
    localparam int NUM_OUT = 9;
    localparam int DATA_W  = 1536;
    localparam int LAST_W  = 12;
    localparam int CNT_W   = 16;
    localparam int SI_W    = $clog2(NUM_IN + 1);
    localparam int SO_W    = $clog2(NUM_OUT + 1);
`ifdef STREAM_XBAR_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [SI_W-1:0]           sel_in;
    logic [SO_W-1:0]           sel_out;
    logic                      s_side;
    logic [NUM_IN*DATA_W-1:0]  s_tdata;
    logic [NUM_IN-1:0]         s_tvalid;
    logic [NUM_IN-1:0]         s_tready;
    logic [NUM_IN*LAST_W-1:0]  s_tlast;
    logic [DATA_W-1:0]         m_tdata;
    logic [LAST_W-1:0]         m_tlast;
    logic                      m_side;
    logic [NUM_OUT-1:0]        m_tvalid;
    logic [NUM_OUT-1:0]        m_tready;
    logic                      busy;
    logic                      pkt_done;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      err_drop;

    stream_xbar_pkt #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .LAST_W(LAST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sel_in(sel_in), .sel_out(sel_out), .s_side(s_side),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_side(m_side), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .busy(busy), .pkt_done(pkt_done), .beat_cnt(beat_cnt),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SO_W-1:0]    idx;
        logic               side;
        logic [LAST_W-1:0]  last;
        logic [DATA_W-1:0]  data;
        logic [NUM_OUT-1:0] mask;
    } beat_t;

    beat_t            q[$];
    bit               m_locked;
    int               m_lock_in;
    logic [SO_W-1:0]  m_lock_out;
    logic [CNT_W-1:0] m_cnt;
    bit               m_err;
    bit               m_done;
    int               total = 0;
    int               bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] fold(input logic [DATA_W-1:0] d);
        logic [63:0] acc = 64'd0;
        for (int k = 0; k < DATA_W / 32; k++)
            acc = acc + 64'(d[k*32 +: 32]) * 64'(k + 1);
        return acc;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic set_lane(input int lane, input logic v, input logic [LAST_W-1:0] l,
                            input logic [DATA_W-1:0] d);
        s_tvalid[lane]                  = v;
        s_tlast[lane*LAST_W +: LAST_W]  = l;
        s_tdata[lane*DATA_W +: DATA_W]  = d;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic step(output bit acc);
        int                 effin;
        bit                 pop, drop;
        beat_t              b;
        logic [NUM_IN-1:0]  rexp;
        logic [NUM_OUT-1:0] vexp;
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            check_val("rst_rdy", 64'(s_tready), 64'd0);
            @(posedge clk);
            q.delete();
            m_locked = 0; m_cnt = '0; m_err = 0; m_done = 0;
        end else begin
            effin = m_locked ? m_lock_in : int'(sel_in);
            for (int i = 0; i < NUM_IN; i++) rexp[i] = (effin == i + 1) && (q.size() < 2);
            check_val("s_tready", 64'(s_tready), 64'(rexp));
            vexp = '0; pop = 0; drop = 0;
            if (q.size() > 0) begin
                if (int'(q[0].idx) < NUM_OUT) begin
                    vexp[q[0].idx] = 1'b1;
                    pop = m_tready[q[0].idx];
                end else if (BCAST && q[0].idx == '1) begin
                    vexp = ~q[0].mask;
                    pop  = &(q[0].mask | m_tready);
                end else begin
                    pop = 1; drop = 1;
                end
            end
            check_val("m_tvalid", 64'(m_tvalid), 64'(vexp));
            if (q.size() > 0) begin
                check_val("data_lo", m_tdata[63:0], q[0].data[63:0]);
                check_val("data_sum", fold(m_tdata), fold(q[0].data));
                check_val("m_tlast", 64'(m_tlast), 64'(q[0].last));
                check_val("m_side", 64'(m_side), 64'(q[0].side));
            end
            check_val("busy", 64'(busy), 64'(m_locked || q.size() > 0));
            check_val("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            check_val("err_drop", 64'(err_drop), 64'(m_err));
            check_val("pkt_done", 64'(pkt_done), 64'(m_done));
            if (effin >= 1 && effin <= NUM_IN && q.size() < 2 && s_tvalid[effin-1]) begin
                acc    = 1'b1;
                b.idx  = m_locked ? m_lock_out : sel_out;
                b.side = s_side;
                b.last = s_tlast[(effin-1)*LAST_W +: LAST_W];
                b.data = s_tdata[(effin-1)*DATA_W +: DATA_W];
                b.mask = '0;
            end
            @(posedge clk);
            m_done = pop && (q[0].last != '0);
            if (drop) m_err = 1;
            if (pop) void'(q.pop_front());
            else if (q.size() > 0) q[0].mask = q[0].mask | (m_tready & vexp);
            if (acc) begin
                q.push_back(b);
                m_cnt = m_cnt + 1'b1;
                if (!m_locked && b.last == '0) begin
                    m_locked = 1; m_lock_in = effin; m_lock_out = sel_out;
                end else if (m_locked && b.last != '0) begin
                    m_locked = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        s_tvalid = '0; s_tlast = '0; s_side = 1'b0;
    endtask

    bit                acc;
    int                sent;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] beats [8];
    bit                tpat [5] = '{1, 0, 0, 1, 1};

    initial begin
        rst = 1'b1; sel_in = '0; sel_out = '0; s_side = 1'b0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = '0;
        m_locked = 0; m_lock_in = 0; m_lock_out = '0; m_cnt = '0; m_err = 0; m_done = 0;
        #1;
        step(acc); step(acc);
        rst = 1'b0;
        check_val("rst_mvalid", 64'(m_tvalid), 64'd0);
        check_val("rst_mdata", m_tdata[63:0], 64'd0);
        check_val("rst_mlast", 64'(m_tlast), 64'd0);
        check_val("rst_cnt", 64'(beat_cnt), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);

        // Single-beat packet, input 1 to output 2
        for (int k = 0; k < DATA_W / 8; k++) pat[k*8 +: 8] = 8'hA5;
        sel_in = 3'd1; sel_out = 4'd2; m_tready = '1; s_side = 1'b1;
        set_lane(0, 1'b1, 12'h001, pat);
        step(acc);
        check_val("t1_acc", 64'(acc), 64'd1);
        idle_inputs();
        check_val("t1_valid", 64'(m_tvalid), 64'b000000100);
        check_val("t1_data", fold(m_tdata), fold(pat));
        step(acc);
        check_val("t1_done", 64'(pkt_done), 64'd1);
        check_val("t1_cnt", 64'(beat_cnt), 64'd1);
        step(acc);

        // 4-beat packet on input 3 to output 5, sel_out disturbed mid-packet
        sel_in = 3'd3; sel_out = 4'd5; sent = 0;
        for (int c = 0; c < 20 && sent < 4; c++) begin
            set_lane(2, 1'b1, (sent == 3) ? 12'h800 : 12'h000, rand_data());
            step(acc);
            if (acc) sent++;
            if (sent >= 1) sel_out = 4'd0;
        end
        check_val("t2_sent", 64'(sent), 64'd4);
        idle_inputs();
        for (int c = 0; c < 4; c++) step(acc);
        check_val("t2_idle", 64'(busy), 64'd0);

        // Throughput with a stalling consumer
        for (int k = 0; k < 8; k++) beats[k] = rand_data();
        sel_in = 3'd2; sel_out = 4'd1; sent = 0;
        for (int c = 0; c < 60 && (sent < 8 || busy); c++) begin
            if (sent < 8) set_lane(1, 1'b1, (sent == 7) ? 12'h004 : 12'h000, beats[sent]);
            else idle_inputs();
            m_tready = '0;
            m_tready[1] = (sent < 8) ? tpat[c % 5] : 1'b1;
            step(acc);
            if (acc) sent++;
        end
        check_val("t3_sent", 64'(sent), 64'd8);
        idle_inputs(); m_tready = '1;
        step(acc);

        // Invalid output index
        sel_in = 3'd1; sel_out = 4'd12;
        set_lane(0, 1'b1, 12'h001, rand_data());
        step(acc);
        idle_inputs();
        check_val("t4_novalid", 64'(m_tvalid), 64'd0);
        step(acc);
        for (int c = 0; c < 3; c++) step(acc);
        check_val("t4_err", 64'(err_drop), 64'd1);

        // Reset while locked with a beat buffered
        sel_in = 3'd4; sel_out = 4'd3; m_tready = '0;
        set_lane(3, 1'b1, 12'h000, rand_data());
        step(acc);
        idle_inputs();
        step(acc);
        check_val("t5_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1; step(acc); rst = 1'b0;
        check_val("t5_valid", 64'(m_tvalid), 64'd0);
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_cnt", 64'(beat_cnt), 64'd0);
        check_val("t5_err", 64'(err_drop), 64'd0);
        sel_in = 3'd5; sel_out = 4'd4; m_tready = '1;
        set_lane(4, 1'b1, 12'h010, rand_data());
        step(acc);
        check_val("t5_newsel", 64'(acc), 64'd1);
        idle_inputs();
        step(acc); step(acc);

        // All-ones output code: broadcast with staggered readies, or a drop without the option
        sel_in = 3'd6; sel_out = '1; m_tready = '0;
        set_lane(5, 1'b1, 12'h001, rand_data());
        step(acc);
        idle_inputs();
        m_tready = 9'b000000111; step(acc);
        m_tready = 9'b000111000; step(acc);
        m_tready = 9'b111000000; step(acc);
        m_tready = '1; step(acc); step(acc);
        check_val("t6_busy", 64'(busy), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            sel_in = SI_W'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: sel_out = 4'd12;
                1: sel_out = '1;
                2: sel_out = 4'd9;
                default: sel_out = SO_W'($urandom_range(0, NUM_OUT - 1));
            endcase
            s_side = 1'($urandom());
            for (int i = 0; i < NUM_IN; i++)
                set_lane(i, 1'($urandom()),
                         ($urandom_range(0, 3) == 0) ? LAST_W'($urandom_range(1, 4095)) : '0,
                         rand_data());
            m_tready = ($urandom_range(0, 3) == 0) ? '1 : NUM_OUT'($urandom());
            step(acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
